// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single-port data memory between instruction fetch (read-only)
// and the MEM stage (read/write). MEM has fixed priority. A starvation guard
// hands the port to a waiting fetch after STARVE_LIMIT consecutive MEM wins.
// The winning request is registered onto the ram_* port. Read data comes
// straight back from the memory one cycle after the grant.
//
// Ports
//   clk, reset               clock, asynchronous active-low reset
//   if_req/if_addr           fetch read request, held until if_gnt
//   if_gnt                   combinational: fetch accepted this cycle
//   if_valid/if_rdata        fetch read data, valid one cycle after if_gnt
//   mem_req/mem_we/mem_addr/mem_wdata
//                            MEM-stage request, held until mem_gnt
//   mem_gnt                  combinational: MEM request accepted this cycle
//   mem_valid/mem_rdata      MEM read data, valid one cycle after a read grant
//   ram_addr/ram_wdata/ram_we registered memory port
//   ram_rdata                memory read data for the registered ram_addr
//   stall_if/stall_mem       request pending but not granted this cycle
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_valid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  mem_req,
    input  logic                  mem_we,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_gnt,
    output logic                  mem_valid,
    output logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  stall_if,
    output logic                  stall_mem
);

    localparam int            CW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    // Owner of the memory port during the current cycle
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] IF_OWN = 2'd1;
    localparam logic [1:0] MEM_RD = 2'd2;
    localparam logic [1:0] MEM_WR = 2'd3;

    logic [1:0]            owner_q,     owner_d;
    logic [CW-1:0]         starve_q,    starve_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q,  ram_addr_d;
    logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
    logic                  ifStarved;

    // Grants are gated by reset so nothing is accepted while the block is
    // held in reset, even though the request inputs may be active.
    assign ifStarved = if_req && (starve_q == LIMIT);
    assign mem_gnt   = reset && mem_req && !ifStarved;
    assign if_gnt    = reset && if_req && !mem_gnt;
    assign stall_if  = reset && if_req && !if_gnt;
    assign stall_mem = reset && mem_req && !mem_gnt;

    // Next-state: the winner's request becomes the port contents next cycle.
    // A fetch has no write data, so ram_wdata keeps its previous value.
    // The starvation count only advances while fetch is actually waiting.
    always_comb begin
        owner_d     = IDLE;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        starve_d    = starve_q;

        if (mem_gnt) begin
            owner_d     = mem_we ? MEM_WR : MEM_RD;
            ram_addr_d  = mem_addr;
            ram_wdata_d = mem_wdata;
        end else if (if_gnt) begin
            owner_d    = IF_OWN;
            ram_addr_d = if_addr;
        end

        if (!if_req || if_gnt) begin
            starve_d = '0;
        end else if (mem_gnt && (starve_q != LIMIT)) begin
            starve_d = starve_q + CW'(1);
        end
    end

    // Reset drops any read in flight, so no valid appears after release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q     <= IDLE;
            starve_q    <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else begin
            owner_q     <= owner_d;
            starve_q    <= starve_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

    // Write enable and valids are pure decodes of the registered owner.
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_we    = (owner_q == MEM_WR);
    assign if_valid  = (owner_q == IF_OWN);
    assign mem_valid = (owner_q == MEM_RD);
    assign if_rdata  = ram_rdata;
    assign mem_rdata = ram_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [7:0]  if_addr;
    logic        if_gnt;
    logic        if_valid;
    logic [15:0] if_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_valid;
    logic [15:0] mem_rdata;
    logic [7:0]  ram_addr;
    logic [15:0] ram_wdata;
    logic        ram_we;
    logic [15:0] ram_rdata;
    logic        stall_if;
    logic        stall_mem;

    int compared   = 0;
    int mismatched = 0;

    // Memory contents as the reference model expects them to be
    logic [15:0] refMem [256];

    // Memory attached to the DUT port: asynchronous read of the registered
    // address, write at the clock edge ending a ram_we cycle.
    logic [15:0] ramData    [256];
    logic        ramWritten [256] = '{default: 1'b0};

    mem_port_arbiter #(
        .ADDR_WIDTH  (8),
        .DATA_WIDTH  (16),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_gnt   (if_gnt),
        .if_valid (if_valid),
        .if_rdata (if_rdata),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_gnt  (mem_gnt),
        .mem_valid(mem_valid),
        .mem_rdata(mem_rdata),
        .ram_addr (ram_addr),
        .ram_wdata(ram_wdata),
        .ram_we   (ram_we),
        .ram_rdata(ram_rdata),
        .stall_if (stall_if),
        .stall_mem(stall_mem)
    );

    // Free-running clock, 10 time units per cycle
    always #5 clk = ~clk;

    function automatic logic [15:0] initVal(input logic [7:0] a);
        return {a ^ 8'hA5, ~a};
    endfunction

    assign ram_rdata = ramWritten[ram_addr] ? ramData[ram_addr] : initVal(ram_addr);

    // Memory write port
    always @(posedge clk) begin
        if (ram_we) begin
            ramData[ram_addr]    <= ram_wdata;
            ramWritten[ram_addr] <= 1'b1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic ifReq, input logic [7:0] ifAddr,
                                 input logic memReq, input logic memWe,
                                 input logic [7:0] memAddr, input logic [15:0] memWdata);
        if_req    = ifReq;
        if_addr   = ifAddr;
        mem_req   = memReq;
        mem_we    = memWe;
        mem_addr  = memAddr;
        mem_wdata = memWdata;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Directed sequence followed by a randomized run against the model
    initial begin
        int          waitCycles;
        int          dutWait;
        bit          ifPend, memPend, memWeR;
        logic [7:0]  ifA, memA, expRamAddr;
        logic [15:0] memD, expIfData, expMemData, expRamWdata;
        bit          expIfValid, expMemValid, expRamWe, eMemGnt, eIfGnt, expIf;

        for (int a = 0; a < 256; a++) refMem[a] = initVal(8'(a));

        // Reset state, with requests active to show grants are held off
        reset = 1'b0;
        applyStimulus(1, 8'h01, 1, 1, 8'h02, 16'h1234);
        @(negedge clk);
        checkOutput("rst_if_gnt", if_gnt, 0);
        checkOutput("rst_mem_gnt", mem_gnt, 0);
        checkOutput("rst_stall_if", stall_if, 0);
        checkOutput("rst_stall_mem", stall_mem, 0);
        checkOutput("rst_if_valid", if_valid, 0);
        checkOutput("rst_mem_valid", mem_valid, 0);
        checkOutput("rst_ram_we", ram_we, 0);
        checkOutput("rst_ram_addr", ram_addr, 0);
        checkOutput("rst_ram_wdata", ram_wdata, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        nextCycle();

        // Reset asserted while a fetch read is in flight
        reset = 1'b1;
        applyStimulus(1, 8'h33, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("t1_if_gnt", if_gnt, 1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("t1_if_valid_before_rst", if_valid, 1);
        #1 reset = 1'b0;
        #1;
        checkOutput("t1_if_valid_in_rst", if_valid, 0);
        checkOutput("t1_ram_we_in_rst", ram_we, 0);
        checkOutput("t1_ram_addr_in_rst", ram_addr, 0);
        nextCycle();
        reset = 1'b1;
        @(negedge clk);
        checkOutput("t1_if_valid_after_rel", if_valid, 0);
        checkOutput("t1_mem_valid_after_rel", mem_valid, 0);
        nextCycle();
        applyStimulus(0, 0, 1, 0, 8'h05, 0);
        @(negedge clk);
        checkOutput("t1_first_mem_gnt", mem_gnt, 1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("t1_first_mem_valid", mem_valid, 1);
        checkOutput("t1_first_mem_rdata", mem_rdata, initVal(8'h05));
        checkOutput("t1_first_ram_addr", ram_addr, 8'h05);
        nextCycle();

        // Back-to-back fetches from 0x10, 0x11, 0x12
        for (int k = 0; k < 5; k++) begin
            if (k < 3) applyStimulus(1, 8'(8'h10 + k), 0, 0, 0, 0);
            else       applyStimulus(0, 0, 0, 0, 0, 0);
            @(negedge clk);
            checkOutput("t2_if_gnt", if_gnt, (k < 3));
            checkOutput("t2_if_valid", if_valid, (k >= 1 && k <= 3));
            if (k >= 1 && k <= 3)
                checkOutput("t2_if_rdata", if_rdata, initVal(8'(8'h10 + k - 1)));
            nextCycle();
        end

        // Write 0x20 <= 0xBEEF then read it back
        applyStimulus(0, 0, 1, 1, 8'h20, 16'hBEEF);
        @(negedge clk);
        checkOutput("t3_wr_gnt", mem_gnt, 1);
        checkOutput("t3_ram_we_c0", ram_we, 0);
        nextCycle();
        applyStimulus(0, 0, 1, 0, 8'h20, 16'h0000);
        @(negedge clk);
        checkOutput("t3_rd_gnt", mem_gnt, 1);
        checkOutput("t3_ram_we_c1", ram_we, 1);
        checkOutput("t3_ram_addr_c1", ram_addr, 8'h20);
        checkOutput("t3_ram_wdata_c1", ram_wdata, 16'hBEEF);
        checkOutput("t3_mem_valid_c1", mem_valid, 0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("t3_ram_we_c2", ram_we, 0);
        checkOutput("t3_mem_valid_c2", mem_valid, 1);
        checkOutput("t3_mem_rdata_c2", mem_rdata, 16'hBEEF);
        nextCycle();
        @(negedge clk);
        checkOutput("t3_mem_valid_c3", mem_valid, 0);
        checkOutput("t3_ram_we_c3", ram_we, 0);
        refMem[8'h20] = 16'hBEEF;
        nextCycle();

        // Both requesting continuously: IF wins every (LIMIT+1)th cycle
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1, 8'h50, 1, 0, 8'h60, 0);
            @(negedge clk);
            expIf = (k == LIMIT) || (k == 2 * LIMIT + 1);
            checkOutput("t4_if_gnt", if_gnt, expIf);
            checkOutput("t4_mem_gnt", mem_gnt, !expIf);
            checkOutput("t4_stall_if", stall_if, !expIf);
            checkOutput("t4_stall_mem", stall_mem, expIf);
            nextCycle();
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
        nextCycle();

        // Single simultaneous fetch and MEM read
        applyStimulus(1, 8'h41, 1, 0, 8'h40, 0);
        @(negedge clk);
        checkOutput("t5_mem_gnt_c0", mem_gnt, 1);
        checkOutput("t5_if_gnt_c0", if_gnt, 0);
        checkOutput("t5_stall_if_c0", stall_if, 1);
        nextCycle();
        applyStimulus(1, 8'h41, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("t5_if_gnt_c1", if_gnt, 1);
        checkOutput("t5_mem_valid_c1", mem_valid, 1);
        checkOutput("t5_mem_rdata_c1", mem_rdata, initVal(8'h40));
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("t5_if_valid_c2", if_valid, 1);
        checkOutput("t5_if_rdata_c2", if_rdata, initVal(8'h41));
        checkOutput("t5_mem_valid_c2", mem_valid, 0);
        nextCycle();
        @(negedge clk);
        checkOutput("t5_if_valid_c3", if_valid, 0);
        nextCycle();

        // Randomized traffic against the reference model
        waitCycles  = 0;
        dutWait     = 0;
        ifPend      = 0;
        memPend     = 0;
        memWeR      = 0;
        ifA         = 0;
        memA        = 0;
        memD        = 0;
        expIfValid  = 0;
        expMemValid = 0;
        expRamWe    = 0;
        expIfData   = 0;
        expMemData  = 0;
        expRamWdata = 0;
        expRamAddr  = 8'h41;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            if (!ifPend && $urandom_range(0, 99) < 55) begin
                ifPend = 1;
                ifA    = 8'($urandom_range(0, 63));
            end
            if (!memPend && $urandom_range(0, 99) < 65) begin
                memPend = 1;
                memWeR  = 1'($urandom_range(0, 1));
                memA    = 8'($urandom_range(0, 63));
                memD    = 16'($urandom);
            end
            applyStimulus(ifPend, ifA, memPend, memWeR, memA, memD);
            @(negedge clk);

            // A waiting fetch wins once it has lost LIMIT cycles in a row
            eMemGnt = memPend && !(ifPend && waitCycles >= LIMIT);
            eIfGnt  = ifPend && !eMemGnt;
            checkOutput("rand_if_gnt", if_gnt, eIfGnt);
            checkOutput("rand_mem_gnt", mem_gnt, eMemGnt);
            checkOutput("rand_both_gnt", if_gnt & mem_gnt, 0);
            checkOutput("rand_stall_if", stall_if, ifPend && !eIfGnt);
            checkOutput("rand_stall_mem", stall_mem, memPend && !eMemGnt);
            checkOutput("rand_if_valid", if_valid, expIfValid);
            checkOutput("rand_mem_valid", mem_valid, expMemValid);
            checkOutput("rand_ram_we", ram_we, expRamWe);
            checkOutput("rand_ram_addr", ram_addr, expRamAddr);
            if (expIfValid)  checkOutput("rand_if_rdata", if_rdata, expIfData);
            if (expMemValid) checkOutput("rand_mem_rdata", mem_rdata, expMemData);
            if (expRamWe)    checkOutput("rand_ram_wdata", ram_wdata, expRamWdata);
            dutWait = stall_if ? dutWait + 1 : 0;
            checkOutput("rand_if_wait_bound", (dutWait <= LIMIT), 1);

            waitCycles  = (ifPend && !eIfGnt) ? waitCycles + 1 : 0;
            expIfValid  = 0;
            expMemValid = 0;
            expRamWe    = 0;
            if (eMemGnt) begin
                expRamAddr = memA;
                if (memWeR) begin
                    refMem[memA] = memD;
                    expRamWe     = 1;
                    expRamWdata  = memD;
                end else begin
                    expMemValid = 1;
                    expMemData  = refMem[memA];
                end
                memPend = 0;
            end else if (eIfGnt) begin
                expRamAddr = ifA;
                expIfValid = 1;
                expIfData  = refMem[ifA];
                ifPend     = 0;
            end
            nextCycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
